// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module  : pipeline_pkg
// Brief   : Shared types and constants for the 5-stage MIPS pipeline.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_if.sv
// ============================================================================
// Module  : id_ex_stage_if
// Brief   : ID-side inputs and EX-side outputs of the ID/EX pipeline register.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface id_ex_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) ();
    import pipeline_pkg::*;

    logic [REG_ADDR_W-1:0] IF_ID_RegRs;
    logic [REG_ADDR_W-1:0] IF_ID_RegRt;
    logic                  ID_UsesRs;
    logic                  ID_UsesRt;
    logic [REG_ADDR_W-1:0] ID_RegRd;
    logic                  ID_RegWrite;
    logic                  ID_MemRead;
    logic                  ID_MemWrite;
    logic                  ID_MemtoReg;
    logic                  ID_ALUSrc;
    logic [1:0]            ID_ALUOp;
    logic [XLEN-1:0]       ID_ReadData1;
    logic [XLEN-1:0]       ID_ReadData2;
    logic [XLEN-1:0]       ID_Imm;
    logic                  Flush_i;
    logic                  Hold_i;

    logic [REG_ADDR_W-1:0] ID_EX_RegRs;
    logic [REG_ADDR_W-1:0] ID_EX_RegRt;
    logic [REG_ADDR_W-1:0] ID_EX_RegRd;
    logic                  ID_EX_RegWrite;
    logic                  ID_EX_MemRead;
    logic                  ID_EX_MemWrite;
    logic                  ID_EX_MemtoReg;
    logic                  ID_EX_ALUSrc;
    logic [1:0]            ID_EX_ALUOp;
    logic [XLEN-1:0]       ID_EX_ReadData1;
    logic [XLEN-1:0]       ID_EX_ReadData2;
    logic [XLEN-1:0]       ID_EX_Imm;
    logic                  Stall_o;
    logic [CNT_W-1:0]      Stall_Count;
    logic [CNT_W-1:0]      Flush_Count;

    modport slave (
        input  IF_ID_RegRs, IF_ID_RegRt, ID_UsesRs, ID_UsesRt, ID_RegRd,
               ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc,
               ID_ALUOp, ID_ReadData1, ID_ReadData2, ID_Imm, Flush_i, Hold_i,
        output ID_EX_RegRs, ID_EX_RegRt, ID_EX_RegRd, ID_EX_RegWrite,
               ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc,
               ID_EX_ALUOp, ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm,
               Stall_o, Stall_Count, Flush_Count
    );

    modport master (
        output IF_ID_RegRs, IF_ID_RegRt, ID_UsesRs, ID_UsesRt, ID_RegRd,
               ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc,
               ID_ALUOp, ID_ReadData1, ID_ReadData2, ID_Imm, Flush_i, Hold_i,
        input  ID_EX_RegRs, ID_EX_RegRt, ID_EX_RegRd, ID_EX_RegWrite,
               ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc,
               ID_EX_ALUOp, ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm,
               Stall_o, Stall_Count, Flush_Count
    );

endinterface

`default_nettype wire

// File: rtl/load_use_detect.sv
// ============================================================================
// Module  : load_use_detect
// Brief   : Combinational load-use hazard check between a load in EX and ID.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module load_use_detect
    import pipeline_pkg::*;
(
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    output logic                  load_use
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = id_uses_rs && (ex_rd == id_rs);
    assign w_rt_hit = id_uses_rt && (ex_rd == id_rt);

    // $0 is hardwired to zero, so a load targeting it never creates a dependency
    assign load_use = ex_mem_read && (ex_rd != '0) && (w_rs_hit || w_rt_hit);

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module  : id_ex_stage
// Brief   : ID/EX pipeline register with load-use bubble, flush, hold and
//           saturating bubble counters.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    id_ex_stage_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_t                 r_ctrl;
    logic [REG_ADDR_W-1:0] r_rs;
    logic [REG_ADDR_W-1:0] r_rt;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [XLEN-1:0]       r_rd1;
    logic [XLEN-1:0]       r_rd2;
    logic [XLEN-1:0]       r_imm;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_flush_cnt;

    ctrl_t                 w_id_ctrl;
    logic                  w_load_use;

    assign w_id_ctrl = '{
        reg_write:  bus.ID_RegWrite,
        mem_read:   bus.ID_MemRead,
        mem_write:  bus.ID_MemWrite,
        mem_to_reg: bus.ID_MemtoReg,
        alu_src:    bus.ID_ALUSrc,
        alu_op:     bus.ID_ALUOp
    };

    load_use_detect u_load_use_detect (
        .ex_mem_read (r_ctrl.mem_read),
        .ex_rd       (r_rd),
        .id_rs       (bus.IF_ID_RegRs),
        .id_rt       (bus.IF_ID_RegRt),
        .id_uses_rs  (bus.ID_UsesRs),
        .id_uses_rt  (bus.ID_UsesRt),
        .load_use    (w_load_use)
    );

    // A flush or hold this cycle means the hazard is either moot or re-evaluated later
    assign bus.Stall_o = w_load_use && !bus.Flush_i && !bus.Hold_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ctrl      <= CTRL_BUBBLE;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_rd1       <= '0;
            r_rd2       <= '0;
            r_imm       <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (bus.Hold_i) begin
            r_ctrl      <= r_ctrl;
        end else if (bus.Flush_i || w_load_use) begin
            r_ctrl <= CTRL_BUBBLE;
            r_rs   <= '0;
            r_rt   <= '0;
            r_rd   <= '0;
            r_rd1  <= '0;
            r_rd2  <= '0;
            r_imm  <= '0;
            if (bus.Flush_i) begin
                if (r_flush_cnt != CNT_MAX)
                    r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end else if (r_stall_cnt != CNT_MAX) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
        end else begin
            r_ctrl <= w_id_ctrl;
            r_rs   <= bus.IF_ID_RegRs;
            r_rt   <= bus.IF_ID_RegRt;
            r_rd   <= bus.ID_RegRd;
            r_rd1  <= bus.ID_ReadData1;
            r_rd2  <= bus.ID_ReadData2;
            r_imm  <= bus.ID_Imm;
        end
    end

    assign bus.ID_EX_RegRs     = r_rs;
    assign bus.ID_EX_RegRt     = r_rt;
    assign bus.ID_EX_RegRd     = r_rd;
    assign bus.ID_EX_RegWrite  = r_ctrl.reg_write;
    assign bus.ID_EX_MemRead   = r_ctrl.mem_read;
    assign bus.ID_EX_MemWrite  = r_ctrl.mem_write;
    assign bus.ID_EX_MemtoReg  = r_ctrl.mem_to_reg;
    assign bus.ID_EX_ALUSrc    = r_ctrl.alu_src;
    assign bus.ID_EX_ALUOp     = r_ctrl.alu_op;
    assign bus.ID_EX_ReadData1 = r_rd1;
    assign bus.ID_EX_ReadData2 = r_rd2;
    assign bus.ID_EX_Imm       = r_imm;
    assign bus.Stall_Count     = r_stall_cnt;
    assign bus.Flush_Count     = r_flush_cnt;

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the 5-stage MIPS pipeline, with load-use hazard detection, bubble insertion, branch flush and hold support. It captures decoded operands and control from the ID stage. It presents the registered ID_EX_RegRs/ID_EX_RegRt/ID_EX_RegRd and control fields to the EX stage and to the forwarding unit. Saturating counters of inserted stall and flush bubbles are exported for performance analysis.

## Interface
Parameters:
- XLEN, 32, datapath width
- CNT_W, 32, width of performance counters

Ports:
- clk_i  in  1  rising-edge clock
- rst_i  in  1  asynchronous, active-high reset
- IF_ID_RegRs  in  5  rs field of instruction in ID
- IF_ID_RegRt  in  5  rt field of instruction in ID
- ID_UsesRs / ID_UsesRt  in  1 each  instruction in ID actually reads rs / rt
- ID_RegRd  in  5  destination register, already muxed by RegDst
- ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc  in  1 each  decoded control
- ID_ALUOp  in  2  decoded ALU op class
- ID_ReadData1, ID_ReadData2, ID_Imm  in  XLEN each  register-file outputs, sign-extended immediate
- Flush_i  in  1  branch/jump resolved taken; squash instruction in ID
- Hold_i  in  1  global freeze (memory wait); register holds contents
- ID_EX_RegRs, ID_EX_RegRt, ID_EX_RegRd  out  5 each  registered register numbers
- ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc  out  1 each
- ID_EX_ALUOp  out  2
- ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm  out  XLEN each
- Stall_o  out  1  combinational; freezes PC and IF/ID this cycle
- Stall_Count, Flush_Count  out  CNT_W each  saturating bubble counters

## Operation
- Load-use hazard (combinational), LU = ID_EX_MemRead && ID_EX_RegRd != 0 && ((ID_UsesRs && ID_EX_RegRd == IF_ID_RegRs) || (ID_UsesRt && ID_EX_RegRd == IF_ID_RegRt)).
- Stall_o = LU && !Flush_i && !Hold_i.
- Per-edge action priority: rst_i > Hold_i > Flush_i > LU > normal.
  - Hold_i: all registered outputs and counters keep their value.
  - Flush_i: bubble loaded; Flush_Count += 1.
  - LU: bubble loaded; Stall_Count += 1.
  - Normal: all ID_* inputs captured.
- Bubble definition: RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc = 0; ALUOp = 0; RegRs/RegRt/RegRd = 0; data fields = 0.
- A bubble has ID_EX_MemRead = 0, so LU self-clears the next cycle. Exactly one bubble is inserted per load-use; no explicit FSM state is needed.
- Counters saturate at all-ones and never wrap.
- Hazards with $0 never stall, whether ID_EX_RegRd = 0 or the matching source is $0.

## Timing
- All ID_EX_* outputs and counters are registered and update on the rising edge of clk_i.
- Capture latency is 1 cycle from ID inputs to ID_EX outputs.
- Stall_o is valid in the same cycle as the offending IF_ID fields. It is deasserted in the cycle after the bubble loads (unless Hold_i intervenes).
- Reset: rst_i asserts asynchronously. All outputs go to 0, including counters; Stall_o goes to 0 because ID_EX_MemRead = 0. A load-use pending at reset is discarded.
- Hold_i during LU: Stall_o = 0; the hazard is re-evaluated after Hold_i drops, and the bubble is then inserted.
- Flush_i coinciding with LU: flush wins. Only Flush_Count increments and Stall_o = 0.

## Structure
- Shared package pipeline_pkg:
  - REG_ADDR_W = 5
  - ALUOp encoding constants
  - packed struct ctrl_t bundling RegWrite/MemRead/MemWrite/MemtoReg/ALUSrc/ALUOp
  - constant CTRL_BUBBLE = all zeros
- Sub-module load_use_detect: combinational LU computation, reusable by a future branch-in-ID hazard unit.
- Register bank and counters are in id_ex_stage.

## Test plan
- Reset mid-run: drive rst_i high between edges -> all outputs 0 immediately, counters 0.
- lw $2 in EX (ID_EX_MemRead=1, ID_EX_RegRd=2), add using rs=2 in ID -> Stall_o=1 that cycle; next edge bubble (ID_EX_RegWrite=0), Stall_Count=1; following cycle Stall_o=0 and add captured.
- lw $0 followed by reader of $0, and lw $5 followed by an instruction with ID_UsesRt=0, rt=5 -> Stall_o=0 in both cases, no bubble.
- Flush_i=1 simultaneous with load-use -> Stall_o=0, bubble loaded, Flush_Count=1, Stall_Count unchanged.
- Hold_i=1 for 3 cycles with changing ID inputs -> ID_EX outputs and counters frozen; after release, capture resumes with the values on the bus.
- Force Stall_Count to all-ones (CNT_W=4 build, 16 load-use events) -> count stays at 15.
